// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP stream adapter.
// Contents: Q4.16 feature format constants, feature type, adapter FSM states,
// wait-counter and statistics widths, and a range-check helper.
package mlp_pkg;

  localparam int unsigned FEAT_W = 20;
  localparam int unsigned FRAC_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;

  localparam logic [FEAT_W-1:0] ONE_Q416 = 20'h10000;

  typedef logic [FEAT_W-1:0] feat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } adapt_state_t;

  // True when a Q4.16 value has any integer bit set, i.e. value >= 1.0.
  function automatic logic over_range(input feat_t f);
    return |f[FEAT_W-1:FRAC_W];
  endfunction

endpackage

// File: rtl/mlp_wait_counter.sv
// Loadable down-counter used to time the core latency.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_load        load i_load_val (takes priority over decrement)
//   i_load_val    value to load
//   i_dec         decrement by one; holds at zero
//   o_zero_c      combinational flag, count is zero
module mlp_wait_counter
  import mlp_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero_c
);

  logic [W-1:0] r_count;

  // Count register: load wins, decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/mlp_stream_adapter.sv
// Streaming front/back end for the MLP classifier core.
// Accepts one 3-feature Q4.16 sample per handshake, holds it on the core
// inputs for CORE_LAT cycles, captures the class decision and returns it with
// a sequence tag and a range-error flag.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               sample channel
//   in_f1..in_f3                    unsigned Q4.16 features
//   core_inp_1..core_inp_3          registered features to the core
//   core_out                        core class decision
//   res_valid/res_ready             result channel
//   res_class, res_tag, res_range_err  result payload
// Optional (macro MLP_ADAPT_STATS_EN):
//   stats_clr                       synchronous clear of the counters
//   cnt_total, cnt_pos              saturating result / positive-result counts
module mlp_stream_adapter
  import mlp_pkg::*;
#(
  parameter int unsigned CORE_LAT = 2,
  parameter int unsigned TAG_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_f1,
  input  logic [FEAT_W-1:0] in_f2,
  input  logic [FEAT_W-1:0] in_f3,
  output logic [FEAT_W-1:0] core_inp_1,
  output logic [FEAT_W-1:0] core_inp_2,
  output logic [FEAT_W-1:0] core_inp_3,
  input  logic              core_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_class,
  output logic [TAG_W-1:0]  res_tag,
`ifdef MLP_ADAPT_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] cnt_total,
  output logic [STAT_W-1:0] cnt_pos,
`endif
  output logic              res_range_err
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CORE_LAT - 1);

  adapt_state_t     r_state;
  logic             r_in_ready;
  feat_t            r_f1, r_f2, r_f3;
  logic             r_res_valid;
  logic             r_res_class;
  logic [TAG_W-1:0] r_tag;
  logic             r_range_err;

  logic w_accept;
  logic w_res_hs;
  logic w_dec;
  logic w_cnt_zero;

  assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;
  assign w_res_hs = r_res_valid && res_ready;
  assign w_dec    = (r_state == WAIT);

  mlp_wait_counter #(
    .W (CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero_c   (w_cnt_zero)
  );

  // Adapter FSM with registered outputs. in_ready stays low for the first
  // cycle after reset and rises on the next edge spent in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_f1        <= '0;
      r_f2        <= '0;
      r_f3        <= '0;
      r_res_valid <= 1'b0;
      r_res_class <= 1'b0;
      r_tag       <= '0;
      r_range_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_f1        <= in_f1;
            r_f2        <= in_f2;
            r_f3        <= in_f3;
            r_range_err <= over_range(in_f1) | over_range(in_f2) | over_range(in_f3);
            r_in_ready  <= 1'b0;
            r_state     <= WAIT;
          end else begin
            r_in_ready  <= 1'b1;
          end
        end
        WAIT: begin
          if (w_cnt_zero) begin
            r_res_class <= core_out;
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          // Re-open the input in the same edge so in_ready is high the
          // cycle after the result handshake.
          if (w_res_hs) begin
            r_res_valid <= 1'b0;
            r_tag       <= r_tag + TAG_W'(1);
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign core_inp_1    = r_f1;
  assign core_inp_2    = r_f2;
  assign core_inp_3    = r_f3;
  assign res_valid     = r_res_valid;
  assign res_class     = r_res_class;
  assign res_tag       = r_tag;
  assign res_range_err = r_range_err;

`ifdef MLP_ADAPT_STATS_EN
  logic [STAT_W-1:0] r_cnt_total;
  logic [STAT_W-1:0] r_cnt_pos;

  // Saturating result counters; a clear in the handshake cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_total <= '0;
      r_cnt_pos   <= '0;
    end else if (stats_clr) begin
      r_cnt_total <= '0;
      r_cnt_pos   <= '0;
    end else if (w_res_hs) begin
      if (r_cnt_total != '1) begin
        r_cnt_total <= r_cnt_total + STAT_W'(1);
      end
      if (r_res_class && (r_cnt_pos != '1)) begin
        r_cnt_pos <= r_cnt_pos + STAT_W'(1);
      end
    end
  end

  assign cnt_total = r_cnt_total;
  assign cnt_pos   = r_cnt_pos;
`endif

endmodule
